pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed-field D/E/M/W pipeline registers.
- One generic stage register with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never loses a beat.
- Supports flush on exception/interrupt, bubble squash, and per-exccode instruction kill (instr forced to nop).
- Carries instr, pc4, exccode and an arbitrary DATA_W payload; instanced between any two pipeline stages.

---
 rtl/pipe_stage_buf_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 78 +++++++
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 tb/tb_pipe_stage_buf.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared exception codes, the default kill mask and the per-slot update ops
// for the generic pipeline stage buffer.
package pipe_stage_buf_pkg;

  localparam int EXC_W_DEF = 5;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] KILL_MASK_DEF = (32'd1 << EXC_ADEL) | (32'd1 << EXC_RI);

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_DROP,
    SLOT_CLEAR
  } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus the instr/pc4/exccode/data payload.
// DROP empties the slot but keeps the payload; CLEAR empties and zeroes it.
module pipe_slot
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int EXC_W  = EXC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  slot_op_e          op,
  input  logic              kill,
  input  logic [31:0]       d_instr,
  input  logic [31:0]       d_pc4,
  input  logic [EXC_W-1:0]  d_exccode,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [31:0]       q_instr,
  output logic [31:0]       q_pc4,
  output logic [EXC_W-1:0]  q_exccode,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_d, valid_q;
  logic [31:0]       instr_d, instr_q;
  logic [31:0]       pc4_d, pc4_q;
  logic [EXC_W-1:0]  exccode_d, exccode_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    exccode_d = exccode_q;
    data_d    = data_q;
    case (op)
      SLOT_LOAD: begin
        valid_d   = 1'b1;
        instr_d   = kill ? 32'h0 : d_instr;
        pc4_d     = d_pc4;
        exccode_d = d_exccode;
        data_d    = d_data;
      end
      SLOT_DROP:  valid_d = 1'b0;
      SLOT_CLEAR: begin
        valid_d   = 1'b0;
        instr_d   = '0;
        pc4_d     = '0;
        exccode_d = '0;
        data_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc4_q     <= '0;
      exccode_q <= '0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      exccode_q <= exccode_d;
      data_q    <= data_d;
    end
  end

  assign q_valid   = valid_q;
  assign q_instr   = instr_q;
  assign q_pc4     = pc4_q;
  assign q_exccode = exccode_q;
  assign q_data    = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, flush, bubble squash, exccode-based instr kill and a stall counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int          DATA_W    = 96,
  parameter int          EXC_W     = EXC_W_DEF,
  parameter logic [31:0] KILL_MASK = KILL_MASK_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc4,
  input  logic [EXC_W-1:0]  in_exccode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc4,
  output logic [EXC_W-1:0]  out_exccode,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_op_e          out_op, skid_op;
  logic              out_from_skid;
  logic              skid_valid;
  logic [31:0]       skid_instr, skid_pc4;
  logic [EXC_W-1:0]  skid_exccode;
  logic [DATA_W-1:0] skid_data;
  logic              acc, dq, enter, kill_in;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  // in_ready comes straight from the SKID valid flop, so out_ready never
  // reaches upstream combinationally.
  assign in_ready = !skid_valid;
  assign acc      = in_valid && in_ready;
  assign dq       = out_valid && out_ready;
  assign enter    = acc && !clr;
  assign kill_in  = (in_exccode != '0) &&
                    (((KILL_MASK >> in_exccode) & 32'd1) != 32'd0);

  always_comb begin
    out_op        = SLOT_HOLD;
    skid_op       = SLOT_HOLD;
    out_from_skid = 1'b0;
    if (flush) begin
      out_op  = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (!out_valid || dq) begin
      if (skid_valid) begin
        out_op        = SLOT_LOAD;
        out_from_skid = 1'b1;
        skid_op       = enter ? SLOT_LOAD : SLOT_DROP;
      end else begin
        out_op = enter ? SLOT_LOAD : SLOT_DROP;
      end
    end else if (enter) begin
      skid_op = SLOT_LOAD;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flush && out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

  // A beat moving SKID -> OUT was already killed when it entered SKID.
  pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_out (
    .clk       (clk),
    .reset     (reset),
    .op        (out_op),
    .kill      (out_from_skid ? 1'b0 : kill_in),
    .d_instr   (out_from_skid ? skid_instr   : in_instr),
    .d_pc4     (out_from_skid ? skid_pc4     : in_pc4),
    .d_exccode (out_from_skid ? skid_exccode : in_exccode),
    .d_data    (out_from_skid ? skid_data    : in_data),
    .q_valid   (out_valid),
    .q_instr   (out_instr),
    .q_pc4     (out_pc4),
    .q_exccode (out_exccode),
    .q_data    (out_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .op        (skid_op),
    .kill      (kill_in),
    .d_instr   (in_instr),
    .d_pc4     (in_pc4),
    .d_exccode (in_exccode),
    .d_data    (in_data),
    .q_valid   (skid_valid),
    .q_instr   (skid_instr),
    .q_pc4     (skid_pc4),
    .q_exccode (skid_exccode),
    .q_data    (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: accepted beats are queued with their
// expected (possibly killed) contents and compared as they leave.
module tb_pipe_stage_buf;

  localparam int DATA_W = 96;
  localparam int EXC_W  = 5;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [31:0]       instr;
    logic [31:0]       pc4;
    logic [EXC_W-1:0]  exccode;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush, clr, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [31:0]       in_instr, in_pc4, out_instr, out_pc4;
  logic [EXC_W-1:0]  in_exccode, out_exccode;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;

  beat_t       sb[$];
  beat_t       head;
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_stall = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc4      (in_pc4),
    .in_exccode  (in_exccode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc4     (out_pc4),
    .out_exccode (out_exccode),
    .out_data    (out_data),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic [EXC_W-1:0] exc);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_pc4     = pc4;
    in_exccode = exc;
    in_data    = {instr ^ 32'hDEAD_BEEF, pc4, instr};
  endtask

  function automatic beat_t expect_beat(input logic [31:0] instr, input logic [31:0] pc4,
                                        input logic [EXC_W-1:0] exc, input logic [DATA_W-1:0] data);
    beat_t b;
    b.instr   = (exc == 5'd4 || exc == 5'd10) ? 32'h0 : instr;
    b.pc4     = pc4;
    b.exccode = exc;
    b.data    = data;
    return b;
  endfunction

  // Decide at the falling edge what the coming rising edge will do.
  always @(negedge clk) begin
    if (reset) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && !out_ready && exp_stall < 32'hFFFF) exp_stall++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            head = sb.pop_front();
            check("sb_instr", out_instr, head.instr);
            check("sb_pc4", out_pc4, head.pc4);
            check("sb_exccode", out_exccode, head.exccode);
            check("sb_data", out_data, head.data);
          end
        end
        if (in_valid && in_ready && !clr)
          sb.push_back(expect_beat(in_instr, in_pc4, in_exccode, in_data));
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc4 = '0; in_exccode = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_cnt, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;

    out_ready = 1'b1;
    drive(32'h2408_0005, 32'h3004, 5'd0);
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_instr", out_instr, 32'h2408_0005);
    check("t1_pc4", out_pc4, 32'h3004);
    check("t1_in_ready", in_ready, 1);
    tick();
    check("t1_empty", out_valid, 0);

    out_ready = 1'b0;
    drive(32'h1111_0001, 32'h1004, 5'd0);
    tick();
    check("bp_a_out", out_instr, 32'h1111_0001);
    drive(32'h2222_0002, 32'h1008, 5'd0);
    tick();
    check("bp_in_ready0", in_ready, 0);
    check("bp_stall1", stall_cnt, 1);
    drive(32'h3333_0003, 32'h100C, 5'd0);
    tick();
    check("bp_stall2", stall_cnt, 2);
    tick();
    check("bp_stall3", stall_cnt, 3);
    check("bp_a_held", out_instr, 32'h1111_0001);
    check("bp_in_ready_still0", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_b_next", out_instr, 32'h2222_0002);
    check("bp_in_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_c_next", out_instr, 32'h3333_0003);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_stall_model", stall_cnt, exp_stall);

    drive(32'hFC00_0000, 32'h100, 5'd10);
    tick();
    check("kill_ri_instr", out_instr, 0);
    check("kill_ri_exc", out_exccode, 10);
    check("kill_ri_pc4", out_pc4, 32'h100);
    check("kill_ri_valid", out_valid, 1);
    drive(32'hFC00_0000, 32'h200, 5'd12);
    tick();
    in_valid = 1'b0;
    check("nokill_ov_instr", out_instr, 32'hFC00_0000);
    check("nokill_ov_exc", out_exccode, 12);
    tick();

    out_ready = 1'b0;
    drive(32'h4444_0004, 32'h2004, 5'd0);
    tick();
    drive(32'h5555_0005, 32'h2008, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid", out_valid, 0);
    check("fl1_in_ready", in_ready, 1);
    tick();
    check("fl1_beat_lost", out_valid, 0);
    check("fl1_stall_held", stall_cnt, exp_stall);

    drive(32'h6666_0006, 32'h3004, 5'd3);
    tick();
    drive(32'h7777_0007, 32'h3008, 5'd5);
    tick();
    check("fl2_full", in_ready, 0);
    drive(32'h8888_0008, 32'h300C, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", out_valid, 0);
    check("fl2_in_ready", in_ready, 1);
    check("fl2_instr", out_instr, 0);
    check("fl2_pc4", out_pc4, 0);
    check("fl2_exc", out_exccode, 0);
    check("fl2_data", out_data, 0);
    tick();
    check("fl2_beat_lost", out_valid, 0);
    check("fl2_stall", stall_cnt, exp_stall);

    out_ready = 1'b1;
    drive(32'h9999_0009, 32'h4004, 5'd0);
    clr = 1'b1;
    check("clr_in_ready", in_ready, 1);
    tick();
    clr = 1'b0;
    check("clr_no_valid", out_valid, 0);
    drive(32'hAAAA_000A, 32'h4008, 5'd0);
    tick();
    in_valid = 1'b0;
    check("clr_next_valid", out_valid, 1);
    check("clr_next_instr", out_instr, 32'hAAAA_000A);
    tick();
    check("sb_drained", sb.size(), 0);

    out_ready = 1'b0;
    drive(32'hBBBB_000B, 32'h5004, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && stall_cnt != 7; i++) tick();
    check("ar_stall7", stall_cnt, 7);
    check("ar_stall_model", stall_cnt, exp_stall);
    #2;
    reset = 1'b0;
    sb.delete();
    exp_stall = 0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_stall0", stall_cnt, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_instr", out_instr, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
